// File: rtl/reg_arbiter.sv
// Four-requester arbiter that serialises writes into one shared WIDTH-bit register.
// Define REG_ARB_FIXED_PRI_EN for fixed priority (lowest index wins); default is round-robin.
module reg_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [3:0]       Req,
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] D2,
   input  logic [WIDTH-1:0] D3,
   output logic [3:0]       Gnt,
   output logic [3:0]       Ack,
   output logic [WIDTH-1:0] Q,
   output logic             QValid,
   output logic             Busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      WRITE   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [1:0]       winner, winner_nxt;
   logic [1:0]       sel;
   logic [3:0]       gnt_nxt, ack_nxt;
   logic [WIDTH-1:0] q_nxt, wdata;
   logic             qvalid_nxt;

`ifdef REG_ARB_FIXED_PRI_EN
   // Scan high to low so the lowest set index is the last (winning) assignment.
   always_comb begin
      sel = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (Req[i]) sel = 2'(i);
      end
   end
`else
   logic [1:0] ptr, ptr_nxt;
   logic [1:0] idx;

   // Offsets scanned far to near so the first set bit at/after ptr wins; 2-bit add wraps 3->0.
   always_comb begin
      sel = 2'd0;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (Req[idx]) sel = idx;
      end
   end
`endif

   always_comb begin
      case (winner)
         2'd0:    wdata = D0;
         2'd1:    wdata = D1;
         2'd2:    wdata = D2;
         default: wdata = D3;
      endcase
   end

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      winner_nxt = winner;
      gnt_nxt    = Gnt;
      ack_nxt    = '0;
      q_nxt      = Q;
      qvalid_nxt = QValid;
`ifndef REG_ARB_FIXED_PRI_EN
      ptr_nxt    = ptr;
`endif
      case (state)
         IDLE: begin
            gnt_nxt = '0;
            if (|Req) begin
               winner_nxt = sel;
               gnt_nxt    = 4'b0001 << sel;
               state_nxt  = GRANT;
            end
         end
         GRANT: begin
            if (Req[winner]) begin
               q_nxt      = wdata;
               qvalid_nxt = 1'b1;
               ack_nxt    = 4'b0001 << winner;
`ifndef REG_ARB_FIXED_PRI_EN
               ptr_nxt    = winner + 2'd1;
`endif
               state_nxt  = WRITE;
            end else begin
               gnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         WRITE: state_nxt = RELEASE;
         RELEASE: begin
            if (!Req[winner]) begin
               gnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= IDLE;
         winner <= 2'd0;
         Gnt    <= '0;
         Ack    <= '0;
         Q      <= '0;
         QValid <= 1'b0;
         Busy   <= 1'b0;
`ifndef REG_ARB_FIXED_PRI_EN
         ptr    <= 2'd0;
`endif
      end else begin
         state  <= state_nxt;
         winner <= winner_nxt;
         Gnt    <= gnt_nxt;
         Ack    <= ack_nxt;
         Q      <= q_nxt;
         QValid <= qvalid_nxt;
         Busy   <= (state_nxt != IDLE);
`ifndef REG_ARB_FIXED_PRI_EN
         ptr    <= ptr_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter: single write, arbitration order, abort, release hold, reset.
// Expectations follow REG_ARB_FIXED_PRI_EN when the bench is built with it defined.
module tb_reg_arbiter;

   localparam int WIDTH = 64;

   logic             Clk = 1'b0;
   logic             Rst;
   logic [3:0]       Req;
   logic [WIDTH-1:0] D0, D1, D2, D3;
   logic [3:0]       Gnt, Ack;
   logic [WIDTH-1:0] Q;
   logic             QValid, Busy;

   int errors = 0;
   int checks = 0;

   reg_arbiter #(.WIDTH(WIDTH)) dut (
      .Clk(Clk), .Rst(Rst), .Req(Req),
      .D0(D0), .D1(D1), .D2(D2), .D3(D3),
      .Gnt(Gnt), .Ack(Ack), .Q(Q), .QValid(QValid), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] d_of(input int w);
      case (w)
         0:       return 64'hDEADBEEF00000001;
         1:       return 64'h1111;
         2:       return 64'h2222;
         default: return 64'h3333;
      endcase
   endfunction

`ifdef REG_ARB_FIXED_PRI_EN
   int rr_order[5] = '{0, 0, 0, 0, 0};
   localparam logic [3:0] AFTER_HOLD_GNT = 4'b0001;
`else
   int rr_order[5] = '{0, 1, 2, 3, 0};
   localparam logic [3:0] AFTER_HOLD_GNT = 4'b1000;
`endif

   initial begin
      Rst = 1'b1;
      Req = 4'b0000;
      D0 = d_of(0); D1 = d_of(1); D2 = d_of(2); D3 = d_of(3);
      tick(); tick();
      Rst = 1'b0;
      check("rst_q", Q, 64'h0);
      check("rst_qvalid", QValid, 1'b0);
      check("rst_gnt", Gnt, 4'b0000);
      check("rst_ack", Ack, 4'b0000);
      check("rst_busy", Busy, 1'b0);

      // Single request from requester 0
      Req = 4'b0001;
      tick();
      check("single_gnt", Gnt, 4'b0001);
      check("single_busy", Busy, 1'b1);
      check("single_q_not_yet", Q, 64'h0);
      tick();
      check("single_q", Q, 64'hDEADBEEF00000001);
      check("single_ack", Ack, 4'b0001);
      check("single_qvalid", QValid, 1'b1);
      Req = 4'b0000;
      tick();
      check("single_ack_pulse", Ack, 4'b0000);
      check("single_release_gnt", Gnt, 4'b0001);
      tick();
      check("single_idle_gnt", Gnt, 4'b0000);
      check("single_idle_busy", Busy, 1'b0);

      // Arbitration order with all four requesting; pointer restarts from reset
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         Req = 4'b1111;
         tick();
         check($sformatf("rr%0d_gnt", k), Gnt, 4'b0001 << rr_order[k]);
         tick();
         check($sformatf("rr%0d_ack", k), Ack, 4'b0001 << rr_order[k]);
         check($sformatf("rr%0d_q", k), Q, d_of(rr_order[k]));
         Req = 4'b1111 & ~(4'b0001 << rr_order[k]);
         tick();
         check($sformatf("rr%0d_ack_clr", k), Ack, 4'b0000);
         tick();
         check($sformatf("rr%0d_idle", k), Gnt, 4'b0000);
      end

      // Abort: requester 2 requests for a single cycle
      Req = 4'b0100;
      tick();
      check("abort_gnt", Gnt, 4'b0100);
      Req = 4'b0000;
      tick();
      check("abort_gnt_clr", Gnt, 4'b0000);
      check("abort_busy", Busy, 1'b0);
      check("abort_ack", Ack, 4'b0000);
      check("abort_q", Q, 64'hDEADBEEF00000001);

      // Pointer unchanged by abort: {3,1} resolves to 1; requester 1 then holds in release
      Req = 4'b1010;
      tick();
      check("hold_gnt", Gnt, 4'b0010);
      tick();
      check("hold_ack", Ack, 4'b0010);
      check("hold_q", Q, 64'h1111);
      Req = 4'b1011;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("hold%0d_gnt", k), Gnt, 4'b0010);
         check($sformatf("hold%0d_busy", k), Busy, 1'b1);
         check($sformatf("hold%0d_ack", k), Ack, 4'b0000);
      end
      Req = 4'b1001;
      tick();
      check("hold_release_gnt", Gnt, 4'b0000);
      check("hold_release_busy", Busy, 1'b0);
      tick();
      check("after_hold_gnt", Gnt, AFTER_HOLD_GNT);
      Req = 4'b0000;
      tick();
      check("after_hold_abort", Gnt, 4'b0000);
      check("after_hold_q", Q, 64'h1111);

      // Reset during the GRANT cycle of a write of D2
      D2 = 64'h5;
      Req = 4'b0100;
      tick();
      check("rst_grant_gnt", Gnt, 4'b0100);
      Rst = 1'b1;
      tick();
      check("rst_grant_q", Q, 64'h0);
      check("rst_grant_qvalid", QValid, 1'b0);
      check("rst_grant_ack", Ack, 4'b0000);
      check("rst_grant_busy", Busy, 1'b0);
      Rst = 1'b0;
      Req = 4'b0000;
      tick();
      check("rst_grant_ack_after", Ack, 4'b0000);
      check("rst_grant_q_after", Q, 64'h0);

      // Reset coincident with a WRITE entry after a completed write
      Req = 4'b0001;
      tick(); tick();
      check("pre_rst_q", Q, 64'hDEADBEEF00000001);
      check("pre_rst_qvalid", QValid, 1'b1);
      Req = 4'b0000;
      tick(); tick();
      Req = 4'b0001;
      tick();
      check("rst_write_gnt", Gnt, 4'b0001);
      Rst = 1'b1;
      tick();
      check("rst_write_q", Q, 64'h0);
      check("rst_write_ack", Ack, 4'b0000);
      check("rst_write_qvalid", QValid, 1'b0);
      Rst = 1'b0;
      Req = 4'b0000;
      tick();
      check("rst_write_busy", Busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
